ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the memory array (power of two, at least 4).
REQ-002 Parameter LATENCY, default 2, meaning cycles from request acceptance to resp_valid (1..15).
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port req_valid  input  1  the CPU presents a request.
REQ-006 Port req_ready  output  1  the block can accept a request this cycle.
REQ-007 Port req_we  input  1  1 = write, 0 = read.
REQ-008 Port req_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 Port req_wdata  input  32  write data.
REQ-010 Port req_be  input  4  byte enables; bit n covers wdata[8n+7:8n].
REQ-011 Port resp_valid  output  1  the response is valid.
REQ-012 Port resp_ready  input  1  the CPU accepts the response.
REQ-013 Port resp_rdata  output  32  read data; 0 for writes.
REQ-014 Port resp_err  output  1  address-range error flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, so at most one request is outstanding.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; addr, we, wdata and be are captured at that edge.
REQ-018 On acceptance, the FSM SHALL go to RESP if LATENCY=1; otherwise it SHALL go to WAIT with a 4-bit counter loaded with LATENCY-2.
REQ-019 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the edge where the counter is 0.
REQ-020 resp_valid SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-021 A write SHALL update only the enabled bytes of word addr[log2(DEPTH_WORDS)+1:2], on the edge that enters RESP.
REQ-022 For a read, resp_rdata SHALL be loaded on the edge that enters RESP, with the array contents at that edge.
REQ-023 For a write, resp_rdata SHALL be 0.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_ready=1.
REQ-025 When resp_ready=1 in RESP, the FSM SHALL return to IDLE on that edge and clear resp_valid; the next request can be accepted one cycle later at the earliest.
REQ-026 resp_ready in IDLE or WAIT SHALL be ignored.
REQ-027 req_be=0000 on a write SHALL leave memory unchanged but still produce a response.
REQ-028 In IDLE, resp_valid SHALL be 0 and resp_rdata SHALL hold its last value.

Reset
REQ-029 While rst_n=0, the block SHALL force state to IDLE, counter to 0, req_ready to 0, resp_valid to 0, resp_rdata to 0 and resp_err to 0, regardless of clk.
REQ-030 req_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-031 Reset during WAIT or RESP SHALL drop the transaction with no response; a write not yet committed is discarded.
REQ-032 The memory array SHALL NOT be reset.

Configuration
REQ-033 With macro RAM_RESPONDER_RANGE_CHECK_EN defined, a request with req_addr >= 4*DEPTH_WORDS SHALL complete with normal timing and resp_err=1.
REQ-034 With that macro defined, such a request SHALL NOT write memory, and resp_rdata SHALL be 0.
REQ-035 Without the macro, the upper address bits SHALL be ignored so the address wraps modulo DEPTH_WORDS, and resp_err SHALL be tied to 0.

Verification
REQ-036 LATENCY=2: write addr 0x10, data 0xDEADBEEF, be=1111, resp_ready held 1 -> resp_valid exactly 2 cycles after acceptance with rdata=0; a following read of 0x10 returns 0xDEADBEEF.
REQ-037 Write 0x00000000 to addr 0x20, then write 0xAABBCCDD with be=0101 -> a read of 0x20 returns 0x00BB00DD.
REQ-038 Read with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable and req_ready=0 throughout; IDLE one cycle after resp_ready=1.
REQ-039 rst_n pulsed low during WAIT of a write to 0x30 whose old value is 0x11111111 -> no response; a later read of 0x30 returns 0x11111111.
REQ-040 With DEPTH_WORDS=1024 and the macro defined, a write to 0x1000 -> resp_err=1 and word 0 is unchanged; without the macro -> resp_err=0 and word 0 is written.
REQ-041 LATENCY=1: back-to-back reads with resp_ready=1 -> resp_valid one cycle after each acceptance; acceptances at most every 2 cycles.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM behind a one-outstanding-request handshake with fixed response latency.
// Optional build macro RAM_RESPONDER_RANGE_CHECK_EN flags and suppresses accesses beyond the array.
module ram_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rerr_q, rerr_d;

    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          err_q;

    logic          reqErr;
    logic          unusedAddr;
    logic          accept;
    logic          goResp;

    logic          txWe;
    logic [AW-1:0] txAddr;
    logic [31:0]   txWdata;
    logic [3:0]    txBe;
    logic          txErr;

`ifdef RAM_RESPONDER_RANGE_CHECK_EN
    assign reqErr     = |req_addr[31:AW+2];
    assign unusedAddr = ^req_addr[1:0];
`else
    assign reqErr     = 1'b0;
    assign unusedAddr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    // ready_q is only ever set while heading into IDLE, so it alone qualifies acceptance
    assign accept = req_valid && ready_q;

    assign goResp = ((state_q == IDLE) && accept && (LATENCY == 1)) ||
                    ((state_q == WAIT) && (cnt_q == 4'd0));

    // With LATENCY=1 the commit edge is the acceptance edge, so the live request is used
    always_comb begin
        txWe    = we_q;
        txAddr  = addr_q;
        txWdata = wdata_q;
        txBe    = be_q;
        txErr   = err_q;
        if (state_q == IDLE) begin
            txWe    = req_we;
            txAddr  = req_addr[AW+1:2];
            txWdata = req_wdata;
            txBe    = req_be;
            txErr   = reqErr;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (goResp) begin
            rvalid_d = 1'b1;
            rerr_d   = txErr;
            rdata_d  = (txWe || txErr) ? 32'd0 : mem[txAddr];
        end
    end

    assign ready_d = (state_d == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= reqErr;
        end
    end

    // The array has no reset; a reset before the commit edge simply never reaches here
    always_ff @(posedge clk) begin
        if (goResp && txWe && !txErr) begin
            for (int b = 0; b < 4; b++) begin
                if (txBe[b]) begin
                    mem[txAddr][8*b +: 8] <= txWdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed checks of ram_responder with LATENCY=2 (u0) and LATENCY=1 (u1).
// Expectations for the out-of-range case follow RAM_RESPONDER_RANGE_CHECK_EN.
module tb_ram_responder;

    logic        clk;
    logic        rst_n;

    logic        valid0, ready0, we0, respValid0, respReady0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;

    logic        valid1, ready1, we1, respValid1, respReady1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  be1;

    int checks   = 0;
    int failures = 0;

    ram_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid0), .req_ready(ready0), .req_we(we0),
        .req_addr(addr0), .req_wdata(wdata0), .req_be(be0),
        .resp_valid(respValid0), .resp_ready(respReady0),
        .resp_rdata(rdata0), .resp_err(err0)
    );

    ram_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid1), .req_ready(ready1), .req_we(we1),
        .req_addr(addr1), .req_wdata(wdata1), .req_be(be1),
        .resp_valid(respValid1), .resp_ready(respReady1),
        .resp_rdata(rdata1), .resp_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // Issues one request on u0 and waits for its response; lat counts edges from acceptance to resp_valid
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input bit retire,
                                 output int lat, output logic [31:0] rdata, output logic err);
        int guard = 0;
        while (ready0 !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        valid0 = 1'b1;
        we0    = we;
        addr0  = addr;
        wdata0 = wdata;
        be0    = be;
        tick();
        valid0 = 1'b0;
        lat = 1;
        while (respValid0 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        rdata = rdata0;
        err   = err0;
        if (retire) tick();
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          accepts;
        bit          lastAccept;
        logic        rdyBefore;
        logic [31:0] expErr, expWord0, expHi;

        rst_n = 1'b1;
        valid0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; be0 = 0; respReady0 = 1;
        valid1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; be1 = 0; respReady1 = 1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_ready_async", {31'd0, ready0}, 32'd0);
        checkOutput("rst_valid_async", {31'd0, respValid0}, 32'd0);
        tick();
        tick();
        checkOutput("rst_ready", {31'd0, ready0}, 32'd0);
        checkOutput("rst_valid", {31'd0, respValid0}, 32'd0);
        checkOutput("rst_rdata", rdata0, 32'd0);
        checkOutput("rst_err", {31'd0, err0}, 32'd0);
        checkOutput("rst_ready_u1", {31'd0, ready1}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("ready_after_rst", {31'd0, ready0}, 32'd1);

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, lat, rd, er);
        checkOutput("wr10_latency", lat, 32'd2);
        checkOutput("wr10_rdata", rd, 32'd0);
        checkOutput("wr10_err", {31'd0, er}, 32'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, lat, rd, er);
        checkOutput("rd10_latency", lat, 32'd2);
        checkOutput("rd10_rdata", rd, 32'hDEADBEEF);

        applyStimulus(1'b1, 32'h20, 32'h00000000, 4'hF, 1'b1, lat, rd, er);
        applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, lat, rd, er);
        applyStimulus(1'b0, 32'h22, 32'h0, 4'h0, 1'b1, lat, rd, er);
        checkOutput("rd20_partial_be", rd, 32'h00BB00DD);

        applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b1, lat, rd, er);
        checkOutput("be0_latency", lat, 32'd2);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, lat, rd, er);
        checkOutput("be0_unchanged", rd, 32'h00BB00DD);

        respReady0 = 1'b0;
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er);
        checkOutput("stall_latency", lat, 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid", {31'd0, respValid0}, 32'd1);
            checkOutput("stall_rdata", rdata0, 32'hDEADBEEF);
            checkOutput("stall_ready", {31'd0, ready0}, 32'd0);
        end
        respReady0 = 1'b1;
        tick();
        checkOutput("stall_release_valid", {31'd0, respValid0}, 32'd0);
        checkOutput("stall_release_ready", {31'd0, ready0}, 32'd1);
        checkOutput("idle_rdata_hold", rdata0, 32'hDEADBEEF);

        applyStimulus(1'b1, 32'h30, 32'h11111111, 4'hF, 1'b1, lat, rd, er);
        valid0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h22222222; be0 = 4'hF;
        tick();
        valid0 = 1'b0;
        checkOutput("abort_in_wait", {31'd0, respValid0}, 32'd0);
        rst_n = 1'b0;
        #2;
        checkOutput("abort_rst_ready", {31'd0, ready0}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_no_resp", {31'd0, respValid0}, 32'd0);
        end
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 1'b1, lat, rd, er);
        checkOutput("abort_rd30", rd, 32'h11111111);

`ifdef RAM_RESPONDER_RANGE_CHECK_EN
        expErr = 32'd1; expWord0 = 32'h01234567; expHi = 32'd0;
`else
        expErr = 32'd0; expWord0 = 32'h55555555; expHi = 32'h55555555;
`endif
        applyStimulus(1'b1, 32'h0, 32'h01234567, 4'hF, 1'b1, lat, rd, er);
        applyStimulus(1'b1, 32'h1000, 32'h55555555, 4'hF, 1'b1, lat, rd, er);
        checkOutput("oor_wr_latency", lat, 32'd2);
        checkOutput("oor_wr_err", {31'd0, er}, expErr);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, lat, rd, er);
        checkOutput("oor_word0", rd, expWord0);
        applyStimulus(1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, lat, rd, er);
        checkOutput("oor_rd_rdata", rd, expHi);
        checkOutput("oor_rd_err", {31'd0, er}, expErr);

        valid1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; wdata1 = 32'hCAFEF00D; be1 = 4'hF;
        tick();
        valid1 = 1'b0;
        checkOutput("l1_wr_valid", {31'd0, respValid1}, 32'd1);
        checkOutput("l1_wr_rdata", rdata1, 32'd0);
        tick();
        checkOutput("l1_idle_ready", {31'd0, ready1}, 32'd1);
        valid1 = 1'b1; we1 = 1'b0;
        accepts = 0;
        lastAccept = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rdyBefore = ready1;
            tick();
            if (rdyBefore === 1'b1) begin
                accepts++;
                checkOutput("l1_rd_valid", {31'd0, respValid1}, 32'd1);
                checkOutput("l1_rd_rdata", rdata1, 32'hCAFEF00D);
                checkOutput("l1_no_consecutive", {31'd0, lastAccept}, 32'd0);
                lastAccept = 1'b1;
            end else begin
                checkOutput("l1_gap_valid", {31'd0, respValid1}, 32'd0);
                lastAccept = 1'b0;
            end
        end
        valid1 = 1'b0;
        checkOutput("l1_accept_count", accepts, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
